mem_access_ctrl: RTL
====================

# mem_access_ctrl

Multi-cycle memory access sequencer for the LC-3 datapath. It captures an address (MAR) and write data (MDR) from the bus when the control store requests an access. It drives the memory interface and waits for memory ready. It then latches read data into MDR and returns a one-cycle completion pulse, the LC-3 "R" signal, to the microsequencer. It sits between the control store, the 16-bit bus and the external memory/MMIO fabric.

## Interface
Parameters:
- `DATA_W`, 16, width of address, data and MAR/MDR registers.
- `TIMEOUT`, 63, maximum cycles spent in ACCESS before abort (used only with `LC3_MEM_TIMEOUT_EN`).

Ports:
- `i_CLK` in 1: single clock; all state updates on the rising edge.
- `i_RST` in 1: synchronous, active-high reset.
- `i_Start` in 1: access request from control store; sampled only in IDLE.
- `i_RW` in 1: 1 = write, 0 = read; sampled with `i_Start`.
- `i_Addr` in DATA_W: address from bus; captured into MAR on accepted start.
- `i_WData` in DATA_W: write data from bus; captured into MDR on accepted write start.
- `o_Busy` in→out 1: high in ACCESS and DONE.
- `o_Done` out 1: one-cycle pulse (R signal), high in DONE.
- `o_MDR` out DATA_W: MDR register contents (gated to bus by GateMDR elsewhere).
- `o_Err` out 1: timeout flag, high in DONE of an aborted access; constant 0 without the macro.
- `o_Mem_En` out 1: memory enable, high throughout ACCESS.
- `o_Mem_WE` out 1: write enable, equals latched RW while in ACCESS, else 0.
- `o_Mem_Addr` out DATA_W: MAR contents.
- `o_Mem_WData` out DATA_W: MDR contents.
- `i_Mem_Data` in DATA_W: read data, valid when `i_Mem_Ready` is high.
- `i_Mem_Ready` in 1: memory completes the access this cycle.

## Operation
- States: IDLE, ACCESS, DONE. Registers: MAR, MDR, latched RW, wait counter (only with the macro), error flag.
- IDLE:
  - `i_Start`=1 captures MAR←`i_Addr` and RW←`i_RW`.
  - If `i_RW`=1, it also captures MDR←`i_WData`; on reads MDR holds its previous value.
  - Next state is ACCESS.
- ACCESS:
  - Asserts `o_Mem_En` and `o_Mem_WE`=RW.
  - If `i_Mem_Ready`=1:
    - On a read, MDR←`i_Mem_Data`.
    - On a write, MDR is unchanged.
    - Next state is DONE.
  - Otherwise the block remains in ACCESS.
- DONE:
  - `o_Done`=1 for exactly one cycle.
  - Next state is IDLE unconditionally.
  - `i_Start` in DONE is ignored.
- `i_Start` while `o_Busy`=1 is ignored. It is neither queued nor captured.
- `i_Addr`, `i_WData` and `i_RW` changes outside an accepted start have no effect.
- MDR is stable from DONE until the next accepted read completes or the next accepted write.
- Reset (at any state, including mid-ACCESS):
  - Next state is IDLE.
  - MAR, MDR, RW, counter and error flag all return to 0.
  - An aborted memory cycle is simply dropped: `o_Mem_En` falls the cycle after reset is sampled.

## Timing
- Reset values:
  - `o_Busy`=0, `o_Done`=0, `o_Err`=0, `o_Mem_En`=0, `o_Mem_WE`=0.
  - `o_MDR`=0, `o_Mem_Addr`=0, `o_Mem_WData`=0.
- All outputs are decoded from registered state/registers; there is no combinational path from inputs to outputs.
- Start accepted at edge 0 → ACCESS in cycle 1. Ready sampled at edge k (k≥1) → DONE in cycle k+1 → IDLE in cycle k+2.
- Minimum latency is start to `o_Done` = 2 cycles. A back-to-back start is accepted in cycle k+2 at the earliest.
- `i_Mem_Ready` outside ACCESS is ignored.

## Configuration
- `LC3_MEM_TIMEOUT_EN` defined:
  - The wait counter clears on entry to ACCESS and increments each ACCESS cycle without ready.
  - When the counter equals `TIMEOUT` without ready, the next state is DONE with `o_Err`=1. MDR←16'h0000 on a read; MDR is unchanged on a write.
  - Ready in the same cycle as the limit wins: normal completion, `o_Err`=0.
  - `o_Err` is valid only during DONE.
- Undefined:
  - There is no counter; ACCESS waits indefinitely for ready.
  - `o_Err` is tied 0.

## Test plan
- Reset then idle → all outputs 0; `i_Mem_Ready` pulses while IDLE cause no state change.
- Read x3000, ready on the first ACCESS cycle with data xBEEF:
  - `o_Mem_En`=1, `o_Mem_WE`=0, `o_Mem_Addr`=x3000 in cycle 1.
  - `o_Done` in cycle 2 with `o_MDR`=xBEEF.
- Write x1234 to xFE06, ready after 3 wait cycles:
  - `o_Mem_WE`=1 for 4 cycles, `o_Mem_WData`=x1234.
  - `o_Done` in cycle 5; MDR stays x1234.
- `i_Start` with a new address asserted during ACCESS and DONE → ignored: MAR unchanged, no second access; a start in the following IDLE cycle is accepted.
- `i_RST` asserted mid-ACCESS of a read → IDLE next cycle, MDR=0, no `o_Done`; a subsequent read completes normally.
- With `LC3_MEM_TIMEOUT_EN` and `TIMEOUT`=4:
  - Ready never asserted → DONE with `o_Err`=1, `o_MDR`=x0000.
  - Ready on the limit cycle → `o_Err`=0 and data latched.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// LC-3 memory access sequencer: MAR/MDR capture, memory handshake, one-cycle R pulse.
// Optional access timeout enabled by defining LC3_MEM_TIMEOUT_EN.
module mem_access_ctrl #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_Start,
  input  logic              i_RW,
  input  logic [DATA_W-1:0] i_Addr,
  input  logic [DATA_W-1:0] i_WData,
  output logic              o_Busy,
  output logic              o_Done,
  output logic [DATA_W-1:0] o_MDR,
  output logic              o_Err,
  output logic              o_Mem_En,
  output logic              o_Mem_WE,
  output logic [DATA_W-1:0] o_Mem_Addr,
  output logic [DATA_W-1:0] o_Mem_WData,
  input  logic [DATA_W-1:0] i_Mem_Data,
  input  logic              i_Mem_Ready
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              rw_q, rw_d;

`ifdef LC3_MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT);
`endif

  // State and datapath registers
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q <= S_IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      rw_q    <= 1'b0;
`ifdef LC3_MEM_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      rw_q    <= rw_d;
`ifdef LC3_MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Next-state and register update logic
  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    rw_d    = rw_q;
`ifdef LC3_MEM_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (i_Start) begin
          mar_d   = i_Addr;
          rw_d    = i_RW;
          state_d = S_ACCESS;
          if (i_RW) begin
            mdr_d = i_WData;
          end
`ifdef LC3_MEM_TIMEOUT_EN
          cnt_d = '0;
          err_d = 1'b0;
`endif
        end
      end
      S_ACCESS: begin
        if (i_Mem_Ready) begin
          state_d = S_DONE;
          if (!rw_q) begin
            mdr_d = i_Mem_Data;
          end
`ifdef LC3_MEM_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          // Abort: ready arriving on the limit cycle is handled above and wins
          state_d = S_DONE;
          err_d   = 1'b1;
          if (!rw_q) begin
            mdr_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state only
  assign o_Busy      = (state_q != S_IDLE);
  assign o_Done      = (state_q == S_DONE);
  assign o_Mem_En    = (state_q == S_ACCESS);
  assign o_Mem_WE    = (state_q == S_ACCESS) & rw_q;
  assign o_MDR       = mdr_q;
  assign o_Mem_Addr  = mar_q;
  assign o_Mem_WData = mdr_q;
`ifdef LC3_MEM_TIMEOUT_EN
  assign o_Err       = (state_q == S_DONE) & err_q;
`else
  assign o_Err       = 1'b0;
`endif

endmodule
